// File: rtl/ceda_pkg.sv
// Shared types and constants for the grayscale frame-buffer stream transmitter.
package ceda_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int unsigned PIX_WIDTH   = 8;
  localparam int unsigned FIFO_DEPTH  = 4;
  localparam int unsigned ENTRY_WIDTH = 10;
  // Committed entries (FIFO + in flight) allowed before another read may issue.
  localparam int unsigned OCC_LIMIT   = FIFO_DEPTH - 2;

  typedef struct packed {
    logic                 user;
    logic                 last;
    logic [PIX_WIDTH-1:0] data;
  } pix_entry_t;

endpackage

// File: rtl/ceda_sync_fifo.sv
// Single-clock FIFO with occupancy count; head entry is presented combinationally from storage.
module ceda_sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
  assign rdata   = mem_q[rd_ptr_q];

  // Storage is cleared too so the head reads as zero out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/ceda_stream_tx.sv
// Reads a frame from byte memory in raster order and streams it out as AXI-Stream pixels.
module ceda_stream_tx
  import ceda_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 1920,
  parameter int unsigned IMG_HEIGHT = 1080,
  parameter int unsigned ADDR_WIDTH = 21
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [PIX_WIDTH-1:0]  mem_rdata,
  output logic [PIX_WIDTH-1:0]  m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic                  m_tuser
);

  localparam int unsigned XW    = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int unsigned YW    = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;

  state_t            state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic              rd_en_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic              iss_user_q, iss_user_d;
  logic              iss_last_q, iss_last_d;
  logic              pend_q, pend_user_q, pend_last_q;
  logic              busy_d, done_d;
  logic              issue, pop, at_x_end, at_y_end, drained;
  logic [CNT_W-1:0]  fifo_count;
  logic [OCC_W-1:0]  occ;
  pix_entry_t        push_entry, head;

  assign m_tvalid = (fifo_count != '0);
  assign pop      = m_tvalid && m_tready;
  assign m_tdata  = head.data;
  assign m_tlast  = head.last;
  assign m_tuser  = head.user;

  assign push_entry = '{user: pend_user_q, last: pend_last_q, data: mem_rdata};

  // Occupancy net of the beat leaving this cycle, so a full-rate stream never throttles.
  assign occ      = OCC_W'(fifo_count) + OCC_W'(mem_rd_en) + OCC_W'(pend_q) - OCC_W'(pop);
  assign at_x_end = (x_q == XW'(IMG_WIDTH - 1));
  assign at_y_end = (y_q == YW'(IMG_HEIGHT - 1));
  assign drained  = !mem_rd_en && !pend_q && (fifo_count == CNT_W'(pop));

  // Next-state, read issue and raster position update.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    rd_en_d    = 1'b0;
    addr_d     = mem_addr;
    iss_user_d = 1'b0;
    iss_last_d = 1'b0;
    busy_d     = busy;
    done_d     = 1'b0;
    issue      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          issue   = 1'b1;
          busy_d  = 1'b1;
          addr_d  = base_addr;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (occ <= OCC_W'(OCC_LIMIT)) begin
          issue  = 1'b1;
          addr_d = mem_addr + ADDR_WIDTH'(1);
        end
      end
      ST_DRAIN: begin
        if (drained) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (issue) begin
      rd_en_d    = 1'b1;
      iss_user_d = (x_q == '0) && (y_q == '0);
      iss_last_d = at_x_end;
      if (at_x_end) begin
        x_d = '0;
        if (at_y_end) begin
          y_d     = '0;
          state_d = ST_DRAIN;
        end else begin
          y_d = y_q + YW'(1);
        end
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  // Registers; pend_* tracks the read whose data is on mem_rdata this cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      mem_rd_en   <= 1'b0;
      mem_addr    <= '0;
      iss_user_q  <= 1'b0;
      iss_last_q  <= 1'b0;
      pend_q      <= 1'b0;
      pend_user_q <= 1'b0;
      pend_last_q <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      mem_rd_en   <= rd_en_d;
      mem_addr    <= addr_d;
      iss_user_q  <= iss_user_d;
      iss_last_q  <= iss_last_d;
      pend_q      <= mem_rd_en;
      pend_user_q <= iss_user_q;
      pend_last_q <= iss_last_q;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

  ceda_sync_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(ENTRY_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (pend_q),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head),
    .count (fifo_count)
  );

endmodule
